axis_to_uart_tx: RTL
====================

// Module: axis_to_uart_tx
// PURPOSE
//  Transmit side of the AXIS<->UART bridge: accepts words on an AXI-Stream slave and serialises each as one
//  UART frame on TX. Frame: start bit, BIT_PER_WORD data bits LSB first, optional parity bit, 1 or 2 stop bits.
//  Complements UART_RX_to_AXIS; both must use identical parameter sets.
// PARAMETERS
//  CLK_FREQ       100     aclk frequency, MHz
//  BIT_RATE       115200  line rate, bit/s
//  BIT_PER_WORD   8       data bits per frame, 5..8
//  PARITY_BIT     0       0 none, 1 odd, 2 even
//  STOP_BITS_NUM  1       1 or 2
// PORTS
//  aclk     in   1             clock, all logic on rising edge
//  aresetn  in   1             reset, asynchronous, active-low
//  tdata    in   8             word; only [BIT_PER_WORD-1:0] sent, upper bits ignored
//  tvalid   in   1             tdata valid
//  tready   out  1             block can accept a word
//  TX       out  1             UART line, idle high
// BEHAVIOUR
//  - Reset: TX=1, tready=0 while aresetn=0, state IDLE, counters 0. tready=1 from first cycle after release.
//    Reset mid-frame aborts at once: TX=1 asynchronously, captured word discarded.
//  - CPB = CLK_FREQ*10**6/BIT_RATE (integer truncation); every bit lasts exactly CPB aclk cycles.
//  - Handshake: transfer on tvalid&&tready. Base build: tready=1 only in IDLE. tdata captured into shift reg.
//  - FSM: IDLE -(transfer)-> START -> DATA (BIT_PER_WORD bits) -> PARITY (if PARITY_BIT!=0) -> STOP1
//    -> STOP2 (if STOP_BITS_NUM==2) -> IDLE. Each non-IDLE state advances on bit-counter terminal count.
//  - TX registered: transfer in cycle N -> TX falls at N+1. Frame length (1+BPW+P+S)*CPB cycles.
//  - Parity: odd -> bit = ~^data; even -> bit = ^data (computed on captured word).
//  - Base build: after last stop bit, IDLE for >=1 cycle (tready=1) before next start bit.
//  - tvalid dropping or tdata changing after transfer has no effect on the frame in flight.
// CONFIGURATION
//  - `UART_TX_SKID_EN defined: one-entry holding register. tready = holding reg empty, independent of FSM.
//    Word accepted mid-frame is held; its start bit begins in the cycle after the last stop bit of the
//    current frame (zero idle gap). Holding reg freed when loaded into shift reg; simultaneous load and
//    new transfer in same cycle allowed (reg refilled).
//  - Not defined: no holding register, behaviour as base build above.
// STRUCTURE
//  - uart_pkg: state enum (IDLE,START,DATA,PARITY,STOP1,STOP2), parity constants PAR_NONE/ODD/EVEN,
//    function cycles_per_bit(clk_mhz, rate); shared with receiver.
//  - Sub-module uart_baud_cnt: $clog2(CPB)-bit counter, enable/clear in, done pulse out at CPB-1.
//  - Elaboration checks: BIT_PER_WORD 5..8, PARITY_BIT 0..2, STOP_BITS_NUM 1..2, CPB>=2.
// TESTING (CLK_FREQ=100, BIT_RATE=10_000_000 -> CPB=10)
//  1 No parity, 1 stop, send 0x55 -> TX 0,1,0,1,0,1,0,1,0,1 each 10 cycles; tready back at cycle 101.
//  2 PARITY_BIT=1, send 0x07 -> parity bit 0; PARITY_BIT=2, send 0x07 -> parity bit 1; frame 110 cycles.
//  3 STOP_BITS_NUM=2, BIT_PER_WORD=7, send 0xFF -> 7 ones then TX high 20 cycles; upper bit ignored.
//  4 aresetn low at cycle 35 of frame -> TX=1 immediately; after release tready=1, next 0xA3 sent intact.
//  5 `UART_TX_SKID_EN, tvalid held high with 0x12,0x34,0x56 -> three frames, no idle gap, tready low only
//    while holding reg full; base build -> exactly 1 idle cycle between frames.
//  6 Loopback into UART_RX_to_AXIS, 256 random words, all parity modes -> tdata matches, tuser=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the AXIS<->UART bridge transmitter and receiver.
// Holds the frame state encoding, parity mode constants and the bit-period helper.
// Both directions import this package so that they always agree on the frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per line bit, truncated; clk_mhz is in MHz, rate in bit/s.
  function automatic int cycles_per_bit(input int clk_mhz, input int rate);
    return (clk_mhz * 1000000) / rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts enabled cycles and pulses done on the last cycle of each bit.
// Latency: done is combinational from the count; the count wraps to 0 on done or clr.
// Backpressure: none; en simply freezes the count.
// Ports: clk/rst_n (async active-low), en (count this cycle), clr (restart at 0),
//        done (high while enabled in cycle CPB-1 of the current bit).
module uart_baud_cnt #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [W-1:0] LAST = W'(CPB - 1);

  logic [W-1:0] cnt;

  assign done = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axis_to_uart_tx.sv
// AXI-Stream slave to UART TX serialiser: start, BIT_PER_WORD data bits LSB first, optional parity, 1-2 stops.
// Latency: TX falls the cycle after the accepting handshake; a frame lasts (1+BPW+P+S)*CPB cycles.
// Backpressure: tready only in IDLE; with UART_TX_SKID_EN a one-word holding register gives back-to-back frames.
// Ports: aclk, aresetn (async active-low), tdata[7:0] (only [BIT_PER_WORD-1:0] sent), tvalid, tready, TX (idle high).
// Build option: define UART_TX_SKID_EN to add the holding register; tready then means "holding register empty".
module axis_to_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  output logic       tready,
  output logic       TX
);

  localparam int CPB = cycles_per_bit(CLK_FREQ, BIT_RATE);

  if (BIT_PER_WORD < 5 || BIT_PER_WORD > 8) begin : g_bad_bpw
    $error("axis_to_uart_tx: BIT_PER_WORD must be 5..8");
  end
  if (PARITY_BIT < 0 || PARITY_BIT > 2) begin : g_bad_par
    $error("axis_to_uart_tx: PARITY_BIT must be 0..2");
  end
  if (STOP_BITS_NUM < 1 || STOP_BITS_NUM > 2) begin : g_bad_stop
    $error("axis_to_uart_tx: STOP_BITS_NUM must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_cpb
    $error("axis_to_uart_tx: clock too slow for bit rate (CPB < 2)");
  end

  uart_state_t             state;
  logic [BIT_PER_WORD-1:0] shreg;
  logic                    par_bit;
  logic [2:0]              bit_idx;
  logic                    tx_q;
  logic                    rdy_q;

  logic                    done;
  logic                    xfer;
  logic                    frame_end;
  logic                    start;
  logic                    rdy_nxt;
  logic [BIT_PER_WORD-1:0] start_word;
  logic                    unused_tdata;

  assign unused_tdata = ^tdata;

  function automatic logic par_of(input logic [BIT_PER_WORD-1:0] w);
    return (PARITY_BIT == PAR_ODD) ? ~^w : ^w;
  endfunction

  assign xfer      = tvalid && rdy_q;
  assign frame_end = done && ((state == STOP2) || (state == STOP1 && STOP_BITS_NUM == 1));

`ifdef UART_TX_SKID_EN
  logic [BIT_PER_WORD-1:0] hold;
  logic                    hold_vld;
  logic                    hold_vld_nxt;
  logic                    can_start;
  logic                    take_direct;
  logic                    hold_fill;

  always_comb begin
    can_start    = (state == IDLE) || frame_end;
    // An accepted word bypasses the holding register only when the line is free and nothing is queued.
    take_direct  = can_start && !hold_vld && xfer;
    hold_fill    = xfer && !take_direct;
    start        = can_start && (hold_vld || xfer);
    start_word   = hold_vld ? hold : tdata[BIT_PER_WORD-1:0];
    hold_vld_nxt = hold_fill ? 1'b1 : (can_start ? 1'b0 : hold_vld);
    rdy_nxt      = !hold_vld_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else begin
      hold_vld <= hold_vld_nxt;
      if (hold_fill) begin
        hold <= tdata[BIT_PER_WORD-1:0];
      end
    end
  end
`else
  always_comb begin
    start      = (state == IDLE) && xfer;
    start_word = tdata[BIT_PER_WORD-1:0];
    // Ready again in the idle cycle that follows the last stop bit.
    rdy_nxt    = ((state == IDLE) && !xfer) || frame_end;
  end
`endif

  uart_baud_cnt #(.CPB(CPB)) u_baud (
    .clk   (aclk),
    .rst_n (aresetn),
    .en    (state != IDLE),
    .clr   (start),
    .done  (done)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
    end else begin
      rdy_q <= rdy_nxt;
      if (start) begin
        state   <= START;
        tx_q    <= 1'b0;
        shreg   <= start_word;
        par_bit <= par_of(start_word);
        bit_idx <= '0;
      end else if (done) begin
        case (state)
          START: begin
            state <= DATA;
            tx_q  <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA: begin
            if (bit_idx == 3'(BIT_PER_WORD - 1)) begin
              bit_idx <= '0;
              if (PARITY_BIT != PAR_NONE) begin
                state <= PARITY;
                tx_q  <= par_bit;
              end else begin
                state <= STOP1;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          PARITY: begin
            state <= STOP1;
            tx_q  <= 1'b1;
          end
          STOP1: begin
            state <= (STOP_BITS_NUM == 2) ? STOP2 : IDLE;
            tx_q  <= 1'b1;
          end
          default: begin
            state <= IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TX     = tx_q;
  assign tready = rdy_q;

endmodule
